// File: rtl/player_action_ctrl.sv
// Player action controller: keycode edge detection, run/jump/fall physics, dash and attack timing.
// Optional macro DOUBLE_JUMP_EN grants one extra airborne jump, re-armed on landing or reset.
module player_action_ctrl #(
    parameter int RUN_SPEED     = 2,
    parameter int JUMP_SPEED    = 8,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 6,
    parameter int DASH_SPEED    = 6,
    parameter int DASH_FRAMES   = 8,
    parameter int DASH_COOLDOWN = 20,
    parameter int ATTACK_FRAMES = 6
) (
    input  logic              i_frame_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_keycode,
    input  logic              i_on_ground,
    input  logic              i_wall_hit,
    output logic signed [9:0] o_vel_x,
    output logic signed [9:0] o_vel_y,
    output logic              o_facing,
    output logic [2:0]        o_state,
    output logic              o_attack_active
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_RISE   = 3'd2,
        ST_FALL   = 3'd3,
        ST_DASH   = 3'd4,
        ST_ATTACK = 3'd5
    } state_t;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_JUMP   = 8'h1A;
    localparam logic [7:0] KEY_ATTACK = 8'h0D;
    localparam logic [7:0] KEY_DASH   = 8'h0E;

    localparam logic signed [9:0] C_RUN      = 10'(RUN_SPEED);
    localparam logic signed [9:0] C_JUMP     = 10'(JUMP_SPEED);
    localparam logic signed [9:0] C_GRAVITY  = 10'(GRAVITY);
    localparam logic signed [9:0] C_MAX_FALL = 10'(MAX_FALL);
    localparam logic signed [9:0] C_DASH     = 10'(DASH_SPEED);
    localparam logic [7:0]        C_DASH_LAST = 8'(DASH_FRAMES - 1);
    localparam logic [7:0]        C_ATK_LAST  = 8'(ATTACK_FRAMES - 1);
    localparam logic [7:0]        C_COOLDOWN  = 8'(DASH_COOLDOWN);

    state_t            r_state;
    logic signed [9:0] r_vel_x;
    logic signed [9:0] r_vel_y;
    logic              r_facing;
    logic              r_attack_active;
    logic [7:0]        r_prev_key;
    logic [7:0]        r_dash_cnt;
    logic [7:0]        r_atk_cnt;
    logic [7:0]        r_cooldown;
`ifdef DOUBLE_JUMP_EN
    logic              r_dj_avail;
`endif

    logic              w_left;
    logic              w_right;
    logic              w_dir;
    logic              w_jump_req;
    logic              w_attack_req;
    logic              w_dash_req;
    logic              w_dash_ok;
    logic              w_wall_block;
    logic              w_air_jump;
    logic              w_facing_n;
    logic signed [9:0] w_steer_vx;
    logic signed [9:0] w_vy_grav;
    logic signed [9:0] w_vy_fall;
    state_t            w_ground_state;

    assign w_left       = (i_keycode == KEY_LEFT);
    assign w_right      = (i_keycode == KEY_RIGHT);
    assign w_dir        = w_left || w_right;
    assign w_jump_req   = (i_keycode == KEY_JUMP)   && (r_prev_key != KEY_JUMP);
    assign w_attack_req = (i_keycode == KEY_ATTACK) && (r_prev_key != KEY_ATTACK);
    assign w_dash_req   = (i_keycode == KEY_DASH)   && (r_prev_key != KEY_DASH);
    assign w_dash_ok    = w_dash_req && (r_state != ST_DASH) && (r_cooldown == 8'd0);

    // Pushing into a touched wall (requested side equals current facing) produces no motion.
    assign w_wall_block = i_wall_hit && ((w_left && !r_facing) || (w_right && r_facing));
    assign w_steer_vx   = w_wall_block ? 10'sd0 : (w_left ? -C_RUN : (w_right ? C_RUN : 10'sd0));
    assign w_facing_n   = w_left ? 1'b0 : (w_right ? 1'b1 : r_facing);
    assign w_vy_grav    = r_vel_y + C_GRAVITY;
    assign w_vy_fall    = (w_vy_grav > C_MAX_FALL) ? C_MAX_FALL : w_vy_grav;
    assign w_ground_state = w_dir ? ST_RUN : ST_IDLE;

`ifdef DOUBLE_JUMP_EN
    assign w_air_jump = w_jump_req && r_dj_avail;
`else
    assign w_air_jump = 1'b0;
`endif

    // Action state machine with all outputs held in registers.
    always_ff @(posedge i_frame_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_vel_x         <= 10'sd0;
            r_vel_y         <= 10'sd0;
            r_facing        <= 1'b1;
            r_attack_active <= 1'b0;
            r_prev_key      <= 8'h00;
            r_dash_cnt      <= 8'd0;
            r_atk_cnt       <= 8'd0;
            r_cooldown      <= 8'd0;
`ifdef DOUBLE_JUMP_EN
            r_dj_avail      <= 1'b1;
`endif
        end else begin
            r_prev_key <= i_keycode;
            if (r_cooldown != 8'd0) begin
                r_cooldown <= r_cooldown - 8'd1;
            end
            if (w_dash_ok) begin
                r_state         <= ST_DASH;
                r_vel_x         <= r_facing ? C_DASH : -C_DASH;
                r_vel_y         <= 10'sd0;
                r_attack_active <= 1'b0;
                r_dash_cnt      <= C_DASH_LAST;
                r_atk_cnt       <= 8'd0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_RUN: begin
`ifdef DOUBLE_JUMP_EN
                        r_dj_avail <= 1'b1;
`endif
                        if (w_attack_req) begin
                            r_state         <= ST_ATTACK;
                            r_vel_x         <= 10'sd0;
                            r_vel_y         <= 10'sd0;
                            r_attack_active <= 1'b1;
                            r_atk_cnt       <= C_ATK_LAST;
                        end else if (w_jump_req && i_on_ground) begin
                            r_state  <= ST_RISE;
                            r_vel_x  <= w_steer_vx;
                            r_vel_y  <= -C_JUMP;
                            r_facing <= w_facing_n;
                        end else if (!i_on_ground) begin
                            r_state  <= ST_FALL;
                            r_vel_x  <= w_steer_vx;
                            r_vel_y  <= 10'sd0;
                            r_facing <= w_facing_n;
                        end else begin
                            r_state  <= w_ground_state;
                            r_vel_x  <= w_steer_vx;
                            r_vel_y  <= 10'sd0;
                            r_facing <= w_facing_n;
                        end
                    end
                    ST_RISE: begin
                        r_vel_x  <= w_steer_vx;
                        r_facing <= w_facing_n;
                        if (w_air_jump) begin
                            r_vel_y <= -C_JUMP;
`ifdef DOUBLE_JUMP_EN
                            r_dj_avail <= 1'b0;
`endif
                        end else begin
                            r_vel_y <= w_vy_fall;
                            r_state <= w_vy_grav[9] ? ST_RISE : ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        r_vel_x  <= w_steer_vx;
                        r_facing <= w_facing_n;
                        if (i_on_ground) begin
                            r_state <= w_ground_state;
                            r_vel_y <= 10'sd0;
                        end else if (w_air_jump) begin
                            r_state <= ST_RISE;
                            r_vel_y <= -C_JUMP;
`ifdef DOUBLE_JUMP_EN
                            r_dj_avail <= 1'b0;
`endif
                        end else begin
                            r_vel_y <= w_vy_fall;
                        end
                    end
                    ST_DASH: begin
                        if ((r_dash_cnt == 8'd0) || i_wall_hit) begin
                            r_state    <= i_on_ground ? ST_IDLE : ST_FALL;
                            r_vel_x    <= 10'sd0;
                            r_vel_y    <= 10'sd0;
                            r_dash_cnt <= 8'd0;
                            r_cooldown <= C_COOLDOWN;
                        end else begin
                            r_dash_cnt <= r_dash_cnt - 8'd1;
                        end
                    end
                    ST_ATTACK: begin
                        if (r_atk_cnt == 8'd0) begin
                            r_state         <= w_ground_state;
                            r_vel_x         <= w_steer_vx;
                            r_facing        <= w_facing_n;
                            r_attack_active <= 1'b0;
                        end else begin
                            r_atk_cnt <= r_atk_cnt - 8'd1;
                        end
                    end
                    default: begin
                        r_state         <= ST_IDLE;
                        r_vel_x         <= 10'sd0;
                        r_vel_y         <= 10'sd0;
                        r_attack_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_vel_x         = r_vel_x;
    assign o_vel_y         = r_vel_y;
    assign o_facing        = r_facing;
    assign o_state         = r_state;
    assign o_attack_active = r_attack_active;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed and randomized bench for player_action_ctrl against a frame-level behavioural model.
module tb_player_action_ctrl;
    localparam int RUN_SPEED     = 2;
    localparam int JUMP_SPEED    = 8;
    localparam int GRAVITY       = 1;
    localparam int MAX_FALL      = 6;
    localparam int DASH_SPEED    = 6;
    localparam int DASH_FRAMES   = 8;
    localparam int DASH_COOLDOWN = 20;
    localparam int ATTACK_FRAMES = 6;
`ifdef DOUBLE_JUMP_EN
    localparam int DJ = 1;
`else
    localparam int DJ = 0;
`endif
    localparam int S_IDLE = 0, S_RUN = 1, S_RISE = 2, S_FALL = 3, S_DASH = 4, S_ATTACK = 5;

    logic              frame_clk;
    logic              reset;
    logic [7:0]        keycode;
    logic              on_ground;
    logic              wall_hit;
    logic signed [9:0] vel_x;
    logic signed [9:0] vel_y;
    logic              facing;
    logic [2:0]        state;
    logic              attack_active;

    int checks;
    int errors;

    // model of the player, one update per frame
    int m_state, m_vx, m_vy, m_face, m_att, m_cd, m_dash_left, m_atk_left, m_prev, m_dj;

    player_action_ctrl #(
        .RUN_SPEED(RUN_SPEED), .JUMP_SPEED(JUMP_SPEED), .GRAVITY(GRAVITY), .MAX_FALL(MAX_FALL),
        .DASH_SPEED(DASH_SPEED), .DASH_FRAMES(DASH_FRAMES), .DASH_COOLDOWN(DASH_COOLDOWN),
        .ATTACK_FRAMES(ATTACK_FRAMES)
    ) dut (
        .i_frame_clk(frame_clk),
        .i_reset(reset),
        .i_keycode(keycode),
        .i_on_ground(on_ground),
        .i_wall_hit(wall_hit),
        .o_vel_x(vel_x),
        .o_vel_y(vel_y),
        .o_facing(facing),
        .o_state(state),
        .o_attack_active(attack_active)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vx"}, vel_x, 0);
        chk({tag, "_vy"}, vel_y, 0);
        chk({tag, "_facing"}, {31'd0, facing}, 1);
        chk({tag, "_state"}, {29'd0, state}, S_IDLE);
        chk({tag, "_attack"}, {31'd0, attack_active}, 0);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_vx"}, vel_x, m_vx);
        chk({tag, "_vy"}, vel_y, m_vy);
        chk({tag, "_facing"}, {31'd0, facing}, m_face);
        chk({tag, "_state"}, {29'd0, state}, m_state);
        chk({tag, "_attack"}, {31'd0, attack_active}, m_att);
    endtask

    task automatic mdl_reset();
        m_state = S_IDLE; m_vx = 0; m_vy = 0; m_face = 1; m_att = 0;
        m_cd = 0; m_dash_left = 0; m_atk_left = 0; m_prev = 0; m_dj = 1;
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic mdl_step(input int key, input int gnd, input int wall);
        int dir, steer, face_n, cd0, nv;
        bit jump, atk, dash, air_jump;
        dir    = (key == 32'h04) ? -1 : ((key == 32'h07) ? 1 : 0);
        jump   = (key == 32'h1A) && (m_prev != 32'h1A);
        atk    = (key == 32'h0D) && (m_prev != 32'h0D);
        dash   = (key == 32'h0E) && (m_prev != 32'h0E);
        face_n = (dir == 0) ? m_face : ((dir > 0) ? 1 : 0);
        steer  = dir * RUN_SPEED;
        if (wall != 0 && dir != 0 && face_n == m_face) steer = 0;
        air_jump = jump && (DJ != 0) && (m_dj != 0);
        m_prev = key;
        cd0 = m_cd;
        if (m_cd > 0) m_cd = m_cd - 1;
        if (dash && m_state != S_DASH && cd0 == 0) begin
            m_state = S_DASH; m_vx = (m_face != 0) ? DASH_SPEED : -DASH_SPEED;
            m_vy = 0; m_att = 0; m_dash_left = DASH_FRAMES;
        end else begin
            case (m_state)
                S_IDLE, S_RUN: begin
                    m_dj = 1;
                    if (atk) begin
                        m_state = S_ATTACK; m_vx = 0; m_vy = 0; m_att = 1; m_atk_left = ATTACK_FRAMES;
                    end else if (jump && gnd != 0) begin
                        m_state = S_RISE; m_vy = -JUMP_SPEED; m_vx = steer; m_face = face_n;
                    end else if (gnd == 0) begin
                        m_state = S_FALL; m_vy = 0; m_vx = steer; m_face = face_n;
                    end else begin
                        m_state = (dir != 0) ? S_RUN : S_IDLE; m_vy = 0; m_vx = steer; m_face = face_n;
                    end
                end
                S_RISE: begin
                    m_vx = steer; m_face = face_n;
                    if (air_jump) begin
                        m_vy = -JUMP_SPEED; m_dj = 0;
                    end else begin
                        nv = m_vy + GRAVITY;
                        m_vy = min_int(nv, MAX_FALL);
                        if (nv >= 0) m_state = S_FALL;
                    end
                end
                S_FALL: begin
                    m_vx = steer; m_face = face_n;
                    if (gnd != 0) begin
                        m_state = (dir != 0) ? S_RUN : S_IDLE; m_vy = 0; m_dj = 1;
                    end else if (air_jump) begin
                        m_state = S_RISE; m_vy = -JUMP_SPEED; m_dj = 0;
                    end else begin
                        m_vy = min_int(m_vy + GRAVITY, MAX_FALL);
                    end
                end
                S_DASH: begin
                    m_dash_left = m_dash_left - 1;
                    if (m_dash_left == 0 || wall != 0) begin
                        m_state = (gnd != 0) ? S_IDLE : S_FALL; m_vx = 0; m_vy = 0; m_cd = DASH_COOLDOWN;
                    end
                end
                S_ATTACK: begin
                    m_atk_left = m_atk_left - 1;
                    if (m_atk_left == 0) begin
                        m_state = (dir != 0) ? S_RUN : S_IDLE; m_vx = steer; m_face = face_n; m_att = 0;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic step(input logic [7:0] key, input logic gnd, input logic wall);
        keycode = key; on_ground = gnd; wall_hit = wall;
        @(posedge frame_clk);
        mdl_step(int'(key), int'(gnd), int'(wall));
        #1;
        compare_all("mdl");
    endtask

    initial begin
        int atk_frames;
        logic [7:0] k;
        logic g;
        logic w;
        checks = 0; errors = 0;
        reset = 1'b1; keycode = 8'h00; on_ground = 1'b1; wall_hit = 1'b0;
        mdl_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        chk_reset("por");
        @(negedge frame_clk);
        reset = 1'b0;

        // run right, held three frames
        repeat (3) step(8'h07, 1'b1, 1'b0);
        chk("run_state", {29'd0, state}, S_RUN);
        chk("run_vx", vel_x, 2);
        chk("run_facing", {31'd0, facing}, 1);

        // jump arc with saturation and landing
        step(8'h00, 1'b1, 1'b0);
        step(8'h1A, 1'b1, 1'b0);
        chk("jump_vy", vel_y, -8);
        chk("jump_state", {29'd0, state}, S_RISE);
        for (int i = 1; i <= 8; i++) begin
            step(8'h1A, 1'b0, 1'b0);
            chk("arc_vy", vel_y, -8 + i);
            chk("arc_state", {29'd0, state}, (i == 8) ? S_FALL : S_RISE);
        end
        repeat (8) step(8'h1A, 1'b0, 1'b0);
        chk("fall_sat_vy", vel_y, 6);
        step(8'h1A, 1'b1, 1'b0);
        chk("land_state", {29'd0, state}, S_IDLE);
        chk("land_vy", vel_y, 0);

        // dash facing left, cooldown rejection then acceptance
        step(8'h04, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h0E, 1'b1, 1'b0);
        chk("dash_state", {29'd0, state}, S_DASH);
        chk("dash_vx", vel_x, -6);
        for (int i = 0; i < 7; i++) begin
            step(8'h00, 1'b1, 1'b0);
            chk("dash_hold_vx", vel_x, -6);
        end
        step(8'h00, 1'b1, 1'b0);
        chk("dash_end_state", {29'd0, state}, S_IDLE);
        repeat (9) step(8'h00, 1'b1, 1'b0);
        step(8'h0E, 1'b1, 1'b0);
        chk("dash_cooldown_reject", {29'd0, state}, S_IDLE);
        repeat (10) step(8'h00, 1'b1, 1'b0);
        step(8'h0E, 1'b1, 1'b0);
        chk("dash_cooldown_accept", {29'd0, state}, S_DASH);
        repeat (8) step(8'h00, 1'b1, 1'b0);
        chk("dash2_end_state", {29'd0, state}, S_IDLE);

        // held attack fires once for a fixed length; dash aborts an attack
        atk_frames = 0;
        for (int i = 0; i < 20; i++) begin
            step(8'h0D, 1'b1, 1'b0);
            if (attack_active === 1'b1) atk_frames++;
        end
        chk("attack_len", atk_frames, 6);
        chk("attack_after_state", {29'd0, state}, S_IDLE);
        step(8'h00, 1'b1, 1'b0);
        step(8'h0D, 1'b1, 1'b0);
        chk("attack_start", {31'd0, attack_active}, 1);
        step(8'h0E, 1'b1, 1'b0);
        chk("attack_abort_dash", {29'd0, state}, S_DASH);
        chk("attack_abort_active", {31'd0, attack_active}, 0);
        repeat (8) step(8'h00, 1'b1, 1'b0);

        // asynchronous reset in frame 4 of a dash
        repeat (21) step(8'h00, 1'b1, 1'b0);
        step(8'h0E, 1'b1, 1'b0);
        chk("pre_reset_dash", {29'd0, state}, S_DASH);
        repeat (3) step(8'h00, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("async_reset");
        mdl_reset();
        @(negedge frame_clk);
        reset = 1'b0;

        // second jump while airborne
        step(8'h00, 1'b1, 1'b0);
        step(8'h1A, 1'b1, 1'b0);
        chk("dj_first_vy", vel_y, -8);
        repeat (2) step(8'h00, 1'b0, 1'b0);
        step(8'h1A, 1'b0, 1'b0);
`ifdef DOUBLE_JUMP_EN
        chk("dj_second_vy", vel_y, -8);
`else
        chk("dj_second_vy", vel_y, -5);
`endif
        repeat (15) step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("dj_land_state", {29'd0, state}, S_IDLE);

        // wall blocks motion only toward the faced side
        step(8'h07, 1'b1, 1'b0);
        step(8'h07, 1'b1, 1'b1);
        chk("wall_block_vx", vel_x, 0);
        chk("wall_block_state", {29'd0, state}, S_RUN);
        step(8'h04, 1'b1, 1'b1);
        chk("wall_away_vx", vel_x, -2);
        chk("wall_away_facing", {31'd0, facing}, 0);

        // randomized frames against the model
        k = 8'h00;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    k = k;
                2:       k = 8'h04;
                3:       k = 8'h07;
                4:       k = 8'h1A;
                5:       k = 8'h0D;
                6:       k = 8'h0E;
                7, 8:    k = 8'h00;
                default: k = 8'($urandom_range(0, 255));
            endcase
            g = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 9) == 0);
            step(k, g, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
